rfm_unit_multibank: RTL and testbench
=====================================

Name: rfm_unit_multibank

Overview:
- Next-generation RFM tracker covering NUM_BANK banks with one instance; replaces per-bank single-table units.
- Each bank has a Misra-Gries tracker: NUM_ENTRY address/count entries plus a spillover count.
- An RFM to a bank selects that bank's hottest row and pushes it into a shared NRR output FIFO with a valid/ready handshake.
- Sits between the command decoder and the near-row-refresh issue logic. Throughput is one command per cycle, 1-cycle table update, no stalls.

Parameters:
- NUM_BANK, 16, number of banks tracked
- BANK_BITS, 4, log2(NUM_BANK)
- NUM_ENTRY, 8, tracker entries per bank
- NUM_ENTRY_BITS, 3, log2(NUM_ENTRY)
- ADDR_SIZE, 18, row address width
- CNT_SIZE, 6, entry/spillover counter width; all counters saturate at 2^CNT_SIZE-1
- NRR_FIFO_DEPTH, 4, NRR output FIFO depth (power of 2)
- RAAIMT, 16, RAA threshold (used only with RFM_RAA_EN)

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous reset, active-high
- act_valid, in, 1, ACT command strobe
- act_bank, in, BANK_BITS, ACT target bank
- act_addr, in, ADDR_SIZE, ACT row address
- rfm_valid, in, 1, RFM command strobe
- rfm_bank, in, BANK_BITS, RFM target bank
- nrr_valid, out, 1, NRR FIFO head valid
- nrr_ready, in, 1, consumer accepts head
- nrr_bank, out, BANK_BITS, head bank
- nrr_addr, out, ADDR_SIZE, head row address
- rfm_req, out, NUM_BANK, per-bank RFM request (RFM_RAA_EN only)
- overflow, out, 1, sticky: NRR dropped because FIFO full
- cmd_err, out, 1, 1-cycle pulse: act_valid and rfm_valid asserted together

Behaviour:
- Reset (async, rst=1) values:
  - all entries invalid, counts 0, spillover 0
  - FIFO empty; nrr_valid=0, nrr_bank=0, nrr_addr=0
  - rfm_req=0, overflow=0, cmd_err=0, RAA counters 0
- ACT sampled at edge N; updates bank act_bank, result visible from N+1. Back-to-back commands always see the prior update. Update rules in priority order:
  - (a) hit: valid entry with matching address -> count+1 (saturating).
  - (b) miss, and an entry exists that is invalid or has count==spillover: lowest such index is replaced -> valid=1, address=act_addr, count=spillover+1 (saturating).
  - (c) otherwise -> spillover+1 (saturating).
- RFM sampled at edge N on bank rfm_bank:
  - Candidate is the valid entry with maximum count; ties go to the lowest index.
  - If candidate count > spillover: push {rfm_bank, address} to FIFO at edge N and set candidate count := spillover. nrr_valid is visible from N+1 when the FIFO was empty.
  - Otherwise (no valid entry, or max <= spillover): no push, table unchanged.
- Simultaneous act_valid and rfm_valid: the RFM executes, the ACT is dropped, and cmd_err pulses at N+1.
- FIFO:
  - Pop on nrr_valid && nrr_ready.
  - Push into a full FIFO: the entry is dropped, the table is still updated, overflow sets and stays set until reset.
  - Push and pop in the same cycle while full: the pop occurs first, so the push succeeds.
  - nrr_bank/nrr_addr hold the head value; they are 0 when empty.
- Pointer arithmetic is modulo NRR_FIFO_DEPTH, with an extra wrap bit for the full/empty distinction.
- Reset asserted mid-operation clears everything immediately, including pending FIFO entries.

Optional Feature:
- Macro: RFM_RAA_EN.
- Defined: each bank has a CNT_SIZE RAA counter.
  - ACT increments it (saturating).
  - RFM subtracts RAAIMT, floored at 0.
  - rfm_req[b] is registered, = (RAA[b] >= RAAIMT), and updates one cycle after the counter changes.
  - A cmd_err-dropped ACT does not count.
- Undefined: no RAA counters; rfm_req is tied to 0; the RAAIMT parameter is unused.

Decomposition:
- Package rfm_pkg holds the NRR entry struct {bank, addr}, counter saturation max constant and tie-break/priority-encoder helper function.
- Sub-module mg_tracker_bank holds one bank's table and spillover:
  - inputs: act_en, rfm_en, addr
  - outputs: nrr_push, nrr_addr
  - instantiated NUM_BANK times via generate.
- Top holds command decode, FIFO and RAA logic.

Test Plan:
- Fill and replace (NUM_ENTRY=4): ACT bank0 rows A,B,C,D, then E -> 4 entries count 1, spillover 1. Next ACT E -> replaces lowest-index entry with count==1 (A slot), E count 2.
- Hit and RFM: ACT bank3 row 0x155 three times, then RFM bank3 -> nrr_valid from N+1 with nrr_bank=3, nrr_addr=0x155; entry count becomes spillover (0). Second RFM -> no push.
- Bank isolation: ACT bank1 row X x5, RFM bank2 -> no NRR. RFM bank1 -> NRR bank1/X.
- FIFO full (DEPTH=4, nrr_ready=0): 5 qualifying RFMs -> 4 entries held, overflow=1. Then nrr_ready=1 drains 4 entries in order, then nrr_valid=0.
- Simultaneous: act_valid=rfm_valid=1, bank0 -> cmd_err pulse 1 cycle, ACT not counted, RFM processed normally. Async rst mid-burst -> all outputs 0 immediately.
- RFM_RAA_EN (RAAIMT=16): 16 ACTs bank5 -> rfm_req[5]=1. RFM bank5 -> rfm_req[5]=0 after update; 20 ACTs then one RFM -> RAA=4.

Source files
------------

// File: rtl/rfm_pkg.sv
// Shared types and helpers for the multi-bank RFM tracker: NRR entry layout,
// counter saturation limit and the lowest-index priority encoder.
package rfm_pkg;

  localparam int RFM_BANK_BITS = 4;
  localparam int RFM_ADDR_SIZE = 18;
  localparam int RFM_CNT_SIZE  = 6;
  localparam logic [RFM_CNT_SIZE-1:0] CNT_MAX = '1;

  localparam int PRIO_W     = 32;
  localparam int PRIO_IDX_W = 5;

  typedef struct packed {
    logic [RFM_BANK_BITS-1:0] bank;
    logic [RFM_ADDR_SIZE-1:0] addr;
  } nrr_entry_t;

  // Index of the lowest set bit; callers qualify the result with |vec.
  function automatic logic [PRIO_IDX_W-1:0] first_set(input logic [PRIO_W-1:0] vec);
    logic [PRIO_IDX_W-1:0] idx;
    idx = '0;
    for (int i = PRIO_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = PRIO_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mg_tracker_bank.sv
// One bank's Misra-Gries tracker: NUM_ENTRY address/count slots plus a
// spillover count. ACT updates the table, RFM nominates the hottest row.
module mg_tracker_bank
  import rfm_pkg::*;
#(
  parameter int NUM_ENTRY      = 8,
  parameter int NUM_ENTRY_BITS = 3,
  parameter int ADDR_SIZE      = 18,
  parameter int CNT_SIZE       = RFM_CNT_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 act_en,
  input  logic                 rfm_en,
  input  logic [ADDR_SIZE-1:0] addr,
  output logic                 nrr_push,
  output logic [ADDR_SIZE-1:0] nrr_addr
);

  localparam logic [CNT_SIZE-1:0] SAT_MAX = '1;

  logic [NUM_ENTRY-1:0] valid_q, valid_d;
  logic [ADDR_SIZE-1:0] addr_q [NUM_ENTRY];
  logic [ADDR_SIZE-1:0] addr_d [NUM_ENTRY];
  logic [CNT_SIZE-1:0]  cnt_q  [NUM_ENTRY];
  logic [CNT_SIZE-1:0]  cnt_d  [NUM_ENTRY];
  logic [CNT_SIZE-1:0]  spill_q, spill_d;

  logic [NUM_ENTRY-1:0]      hit_vec, free_vec;
  logic [NUM_ENTRY_BITS-1:0] hit_idx, free_idx, best_idx;
  logic                      hit_any, free_any, best_valid;
  logic [CNT_SIZE-1:0]       best_cnt;

  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
    return (v == SAT_MAX) ? v : v + 1'b1;
  endfunction

  // A slot is replaceable when empty or when its count has fallen to spillover.
  always_comb begin
    hit_vec  = '0;
    free_vec = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      hit_vec[i]  = valid_q[i] && (addr_q[i] == addr);
      free_vec[i] = !valid_q[i] || (cnt_q[i] == spill_q);
    end
  end

  assign hit_any  = |hit_vec;
  assign free_any = |free_vec;
  assign hit_idx  = NUM_ENTRY_BITS'(first_set(PRIO_W'(hit_vec)));
  assign free_idx = NUM_ENTRY_BITS'(first_set(PRIO_W'(free_vec)));

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_valid = 1'b0;
    best_idx   = '0;
    best_cnt   = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (valid_q[i] && (!best_valid || (cnt_q[i] > best_cnt))) begin
        best_valid = 1'b1;
        best_idx   = NUM_ENTRY_BITS'(i);
        best_cnt   = cnt_q[i];
      end
    end
  end

  assign nrr_push = rfm_en && best_valid && (best_cnt > spill_q);
  assign nrr_addr = addr_q[best_idx];

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    spill_d = spill_q;
    if (rfm_en) begin
      if (nrr_push) cnt_d[best_idx] = spill_q;
    end else if (act_en) begin
      if (hit_any) begin
        cnt_d[hit_idx] = sat_inc(cnt_q[hit_idx]);
      end else if (free_any) begin
        valid_d[free_idx] = 1'b1;
        addr_d[free_idx]  = addr;
        cnt_d[free_idx]   = sat_inc(spill_q);
      end else begin
        spill_d = sat_inc(spill_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      addr_q  <= '{default: '0};
      cnt_q   <= '{default: '0};
      spill_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      spill_q <= spill_d;
    end
  end

endmodule

// File: rtl/rfm_unit_multibank.sv
// Multi-bank RFM tracker top: command decode, per-bank trackers, shared NRR
// FIFO. Optional per-bank RAA counters and rfm_req under macro RFM_RAA_EN.
module rfm_unit_multibank
  import rfm_pkg::*;
#(
  parameter int NUM_BANK       = 16,
  parameter int BANK_BITS      = RFM_BANK_BITS,
  parameter int NUM_ENTRY      = 8,
  parameter int NUM_ENTRY_BITS = 3,
  parameter int ADDR_SIZE      = RFM_ADDR_SIZE,
  parameter int CNT_SIZE       = RFM_CNT_SIZE,
  parameter int NRR_FIFO_DEPTH = 4,
  parameter int RAAIMT         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 act_valid,
  input  logic [BANK_BITS-1:0] act_bank,
  input  logic [ADDR_SIZE-1:0] act_addr,
  input  logic                 rfm_valid,
  input  logic [BANK_BITS-1:0] rfm_bank,
  output logic                 nrr_valid,
  input  logic                 nrr_ready,
  output logic [BANK_BITS-1:0] nrr_bank,
  output logic [ADDR_SIZE-1:0] nrr_addr,
  output logic [NUM_BANK-1:0]  rfm_req,
  output logic                 overflow,
  output logic                 cmd_err
);

  localparam int PTR_W = $clog2(NRR_FIFO_DEPTH);

  logic [NUM_BANK-1:0]  act_en, rfm_en, push_vec;
  logic [ADDR_SIZE-1:0] bank_addr [NUM_BANK];

  // RFM wins a same-cycle collision; the ACT is discarded everywhere.
  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    assign act_en[b] = act_valid && !rfm_valid && (act_bank == BANK_BITS'(b));
    assign rfm_en[b] = rfm_valid && (rfm_bank == BANK_BITS'(b));

    mg_tracker_bank #(
      .NUM_ENTRY      (NUM_ENTRY),
      .NUM_ENTRY_BITS (NUM_ENTRY_BITS),
      .ADDR_SIZE      (ADDR_SIZE),
      .CNT_SIZE       (CNT_SIZE)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .act_en   (act_en[b]),
      .rfm_en   (rfm_en[b]),
      .addr     (act_addr),
      .nrr_push (push_vec[b]),
      .nrr_addr (bank_addr[b])
    );
  end

  // NRR FIFO handshake: nrr_valid means the head holds an entry; it is
  // consumed on a rising edge where nrr_valid && nrr_ready. nrr_bank and
  // nrr_addr are stable while nrr_valid is high and not yet consumed.
  nrr_entry_t         mem_q [NRR_FIFO_DEPTH];
  nrr_entry_t         push_entry, head;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d, cmd_err_q;
  logic               push, pop, full, empty, push_ok;

  assign push            = |push_vec;
  assign push_entry.bank = rfm_bank;
  assign push_entry.addr = bank_addr[rfm_bank];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop     = !empty && nrr_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO lands.
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push && !push_ok) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      cmd_err_q  <= act_valid && rfm_valid;
    end
  end

  assign head      = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign nrr_valid = !empty;
  assign nrr_bank  = head.bank;
  assign nrr_addr  = head.addr;
  assign overflow  = overflow_q;
  assign cmd_err   = cmd_err_q;

`ifdef RFM_RAA_EN
  localparam logic [CNT_SIZE-1:0] RAA_TH  = CNT_SIZE'(RAAIMT);
  localparam logic [CNT_SIZE-1:0] RAA_MAX = CNT_MAX;

  logic [CNT_SIZE-1:0] raa_q [NUM_BANK];
  logic [CNT_SIZE-1:0] raa_d [NUM_BANK];
  logic [NUM_BANK-1:0] rfm_req_q;

  always_comb begin
    raa_d = raa_q;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (act_en[b]) begin
        if (raa_q[b] != RAA_MAX) raa_d[b] = raa_q[b] + 1'b1;
      end else if (rfm_en[b]) begin
        raa_d[b] = (raa_q[b] >= RAA_TH) ? raa_q[b] - RAA_TH : '0;
      end
    end
  end

  // rfm_req follows the counter one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raa_q     <= '{default: '0};
      rfm_req_q <= '0;
    end else begin
      raa_q <= raa_d;
      for (int b = 0; b < NUM_BANK; b++) rfm_req_q[b] <= (raa_q[b] >= RAA_TH);
    end
  end

  assign rfm_req = rfm_req_q;
`else
  assign rfm_req = '0;
`endif

endmodule

// File: tb/tb_rfm_unit_multibank.sv
// Scoreboard bench for rfm_unit_multibank (NUM_ENTRY=4): directed ACT/RFM
// vectors push expected NRR entries, a negedge monitor pops and compares.
module tb_rfm_unit_multibank;

  localparam int NUM_BANK  = 16;
  localparam int BANK_BITS = 4;
  localparam int ADDR_SIZE = 18;
  localparam int W         = BANK_BITS + ADDR_SIZE;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 act_valid = 1'b0;
  logic [BANK_BITS-1:0] act_bank = '0;
  logic [ADDR_SIZE-1:0] act_addr = '0;
  logic                 rfm_valid = 1'b0;
  logic [BANK_BITS-1:0] rfm_bank = '0;
  logic                 nrr_valid;
  logic                 nrr_ready = 1'b1;
  logic [BANK_BITS-1:0] nrr_bank;
  logic [ADDR_SIZE-1:0] nrr_addr;
  logic [NUM_BANK-1:0]  rfm_req;
  logic                 overflow;
  logic                 cmd_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  rfm_unit_multibank #(
    .NUM_BANK       (NUM_BANK),
    .BANK_BITS      (BANK_BITS),
    .NUM_ENTRY      (4),
    .NUM_ENTRY_BITS (2),
    .ADDR_SIZE      (ADDR_SIZE),
    .CNT_SIZE       (6),
    .NRR_FIFO_DEPTH (4),
    .RAAIMT         (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .act_valid (act_valid),
    .act_bank  (act_bank),
    .act_addr  (act_addr),
    .rfm_valid (rfm_valid),
    .rfm_bank  (rfm_bank),
    .nrr_valid (nrr_valid),
    .nrr_ready (nrr_ready),
    .nrr_bank  (nrr_bank),
    .nrr_addr  (nrr_addr),
    .rfm_req   (rfm_req),
    .overflow  (overflow),
    .cmd_err   (cmd_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every accepted NRR entry must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && nrr_valid && nrr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL nrr_unexpected: got bank %0d addr 0x%0h, expected no entry", nrr_bank, nrr_addr);
      end else begin
        logic [W-1:0] exp_e;
        exp_e = exp_q.pop_front();
        check("nrr_entry", 32'({nrr_bank, nrr_addr}), 32'(exp_e));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_act(input logic [BANK_BITS-1:0] b, input logic [ADDR_SIZE-1:0] a);
    act_valid = 1'b1;
    act_bank  = b;
    act_addr  = a;
    tick();
    act_valid = 1'b0;
  endtask

  task automatic do_rfm(input logic [BANK_BITS-1:0] b, input bit expect_push,
                        input logic [ADDR_SIZE-1:0] a);
    if (expect_push) exp_q.push_back({b, a});
    rfm_valid = 1'b1;
    rfm_bank  = b;
    tick();
    rfm_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_valid_idle"}, 32'(nrr_valid), 32'd0);
    check({name, "_head_idle"}, 32'({nrr_bank, nrr_addr}), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_nrr_valid", 32'(nrr_valid), 32'd0);
    check("rst_nrr_head", 32'({nrr_bank, nrr_addr}), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    check("rst_rfm_req", 32'(rfm_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Fill and replace, bank 0: A..D fill, E spills, second E replaces slot 0
    do_act(4'd0, 18'h0000A);
    do_act(4'd0, 18'h0000B);
    do_act(4'd0, 18'h0000C);
    do_act(4'd0, 18'h0000D);
    do_act(4'd0, 18'h0000E);
    do_act(4'd0, 18'h0000E);
    do_rfm(4'd0, 1'b1, 18'h0000E);
    do_rfm(4'd0, 1'b0, 18'h0);
    do_act(4'd0, 18'h0000B);
    do_rfm(4'd0, 1'b1, 18'h0000B);
    do_act(4'd0, 18'h0000A);
    do_rfm(4'd0, 1'b1, 18'h0000A);
    wait_drain("fill_replace");

    // Hit and RFM, bank 3
    for (int i = 0; i < 3; i++) do_act(4'd3, 18'h00155);
    do_rfm(4'd3, 1'b1, 18'h00155);
    do_rfm(4'd3, 1'b0, 18'h0);
    wait_drain("hit_rfm");

    // Bank isolation
    for (int i = 0; i < 5; i++) do_act(4'd1, 18'h2AAAA);
    do_rfm(4'd2, 1'b0, 18'h0);
    wait_drain("isolation_b2");
    do_rfm(4'd1, 1'b1, 18'h2AAAA);
    wait_drain("isolation_b1");

    // Full FIFO with a same-cycle pop: push must be accepted
    nrr_ready = 1'b0;
    for (int b = 10; b < 14; b++) begin
      do_act(BANK_BITS'(b), 18'(b * 16'h0101));
      do_rfm(BANK_BITS'(b), 1'b1, 18'(b * 16'h0101));
    end
    do_act(4'd14, 18'h0E0E);
    check("full_valid", 32'(nrr_valid), 32'd1);
    nrr_ready = 1'b1;
    do_rfm(4'd14, 1'b1, 18'h0E0E);
    wait_drain("push_pop_full");
    check("push_pop_no_overflow", 32'(overflow), 32'd0);

    // Overflow: 5 qualifying RFMs with the consumer stalled
    nrr_ready = 1'b0;
    do_act(4'd4, 18'h00444);
    do_rfm(4'd4, 1'b1, 18'h00444);
    do_act(4'd6, 18'h00666);
    do_rfm(4'd6, 1'b1, 18'h00666);
    do_act(4'd7, 18'h00777);
    do_rfm(4'd7, 1'b1, 18'h00777);
    do_act(4'd8, 18'h00888);
    do_rfm(4'd8, 1'b1, 18'h00888);
    check("ovf_before", 32'(overflow), 32'd0);
    do_act(4'd9, 18'h00999);
    do_rfm(4'd9, 1'b0, 18'h0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head", 32'({nrr_bank, nrr_addr}), 32'({4'd4, 18'h00444}));
    nrr_ready = 1'b1;
    wait_drain("overflow_drain");
    do_rfm(4'd9, 1'b0, 18'h0);
    wait_drain("overflow_table_updated");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous ACT and RFM: RFM runs, ACT dropped, cmd_err pulses
    do_act(4'd15, 18'h000F0);
    do_act(4'd15, 18'h000F0);
    exp_q.push_back({4'd15, 18'h000F0});
    act_valid = 1'b1;
    act_bank  = 4'd15;
    act_addr  = 18'h000F1;
    rfm_valid = 1'b1;
    rfm_bank  = 4'd15;
    tick();
    act_valid = 1'b0;
    rfm_valid = 1'b0;
    check("cmd_err_pulse", 32'(cmd_err), 32'd1);
    tick();
    check("cmd_err_clear", 32'(cmd_err), 32'd0);
    do_rfm(4'd15, 1'b0, 18'h0);
    wait_drain("simultaneous");

`ifdef RFM_RAA_EN
    for (int i = 0; i < 16; i++) do_act(4'd5, 18'h05555);
    tick();
    check("raa_req_set", 32'(rfm_req), 32'h0020);
    do_rfm(4'd5, 1'b1, 18'h05555);
    tick();
    check("raa_req_clear", 32'(rfm_req), 32'h0000);
    for (int i = 0; i < 20; i++) do_act(4'd5, 18'h05555);
    tick();
    check("raa_req_20", 32'(rfm_req), 32'h0020);
    do_rfm(4'd5, 1'b1, 18'h05555);
    tick();
    check("raa_req_after_sub", 32'(rfm_req), 32'h0000);
    for (int i = 0; i < 11; i++) do_act(4'd5, 18'h05555);
    tick();
    check("raa_15", 32'(rfm_req), 32'h0000);
    do_act(4'd5, 18'h05555);
    tick();
    check("raa_16", 32'(rfm_req), 32'h0020);
    wait_drain("raa");
`else
    for (int i = 0; i < 20; i++) do_act(4'd5, 18'h05555);
    tick();
    check("rfm_req_tied", 32'(rfm_req), 32'h0000);
`endif

    // Asynchronous reset mid-burst clears pending FIFO entries and tables
    nrr_ready = 1'b0;
    do_act(4'd2, 18'h02222);
    do_act(4'd2, 18'h02222);
    do_act(4'd3, 18'h00333);
    do_rfm(4'd2, 1'b0, 18'h0);
    check("pre_rst_valid", 32'(nrr_valid), 32'd1);
    act_valid = 1'b1;
    act_bank  = 4'd2;
    act_addr  = 18'h02222;
    rfm_valid = 1'b1;
    rfm_bank  = 4'd2;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(nrr_valid), 32'd0);
    check("async_rst_head", 32'({nrr_bank, nrr_addr}), 32'd0);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    check("async_rst_cmd_err", 32'(cmd_err), 32'd0);
    check("async_rst_rfm_req", 32'(rfm_req), 32'd0);
    act_valid = 1'b0;
    rfm_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    nrr_ready = 1'b1;
    do_rfm(4'd3, 1'b0, 18'h0);
    do_rfm(4'd2, 1'b0, 18'h0);
    wait_drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
